// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: arms timed rounds, judges the captured buzz answer
// against the host key, keeps saturating per-player scores and declares a winner.
module quiz_round_ctrl #(
  parameter int unsigned TIMEOUT   = 500000000,
  parameter int unsigned HOLD      = 100000000,
  parameter int unsigned SCORE_W   = 4,
  parameter int unsigned WIN_SCORE = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gameHasStarted,
  input  logic                   playerInputFlag,
  input  logic                   allButtons,
  input  logic [1:0]             firstPlayerFlag,
  input  logic [7:0]             switchInput,
  input  logic [7:0]             answer_key,
  output logic [4*SCORE_W-1:0]   scores,
  output logic [2:0]             state,
  output logic [1:0]             last_player,
  output logic [1:0]             result,
  output logic                   result_valid,
  output logic [1:0]             winner,
  output logic                   led
);

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned TIMER_W     = 32;

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [SCORE_W-1:0] SCORE_MIN    = '0;
  localparam logic [SCORE_W-1:0] WIN_LEVEL    = SCORE_W'(WIN_SCORE);

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_CORRECT = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SHOW    = 3'd3,
    S_RELEASE = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  state_t                                state_q, state_d;
  logic [TIMER_W-1:0]                    timer_q, timer_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   score_q, score_d;
  logic [1:0]                            last_q, last_d;
  logic [1:0]                            result_q, result_d;
  logic                                  valid_q, valid_d;
  logic [1:0]                            winner_q, winner_d;
  logic                                  led_q, led_d;

  // Judge the captured answer and form the saturated score of that player
  logic                 correct_c;
  logic [SCORE_W-1:0]   cur_score_c;
  logic [SCORE_W-1:0]   new_score_c;

  always_comb begin
    correct_c   = (switchInput == answer_key);
    cur_score_c = score_q[firstPlayerFlag];
    new_score_c = cur_score_c;
    if (correct_c) begin
      if (cur_score_c != SCORE_MAX) new_score_c = cur_score_c + SCORE_W'(1);
    end else begin
      if (cur_score_c != SCORE_MIN) new_score_c = cur_score_c - SCORE_W'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      score_q  <= '0;
      last_q   <= '0;
      result_q <= RES_NONE;
      valid_q  <= 1'b0;
      winner_q <= '0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      score_q  <= score_d;
      last_q   <= last_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      winner_q <= winner_d;
      led_q    <= led_d;
    end
  end

  // Next-state and next-output logic; abort overrides every transition
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    score_d  = score_q;
    last_d   = last_q;
    result_d = result_q;
    valid_d  = 1'b0;
    winner_d = winner_q;
    led_d    = led_q;

    if (allButtons && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      score_d  = '0;
      last_d   = '0;
      result_d = RES_NONE;
      winner_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (gameHasStarted && !playerInputFlag) begin
            state_d = S_ARMED;
            timer_d = '0;
          end
        end

        S_ARMED: begin
          if (playerInputFlag) begin
            state_d = S_CAPTURE;
            timer_d = '0;
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d  = S_SHOW;
            timer_d  = '0;
            result_d = RES_TIMEOUT;
            valid_d  = 1'b1;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end

        // Upstream index/answer registers are valid during this cycle
        S_CAPTURE: begin
          timer_d                  = '0;
          last_d                   = firstPlayerFlag;
          score_d[firstPlayerFlag] = new_score_c;
          result_d                 = correct_c ? RES_CORRECT : RES_WRONG;
          valid_d                  = 1'b1;
          if (new_score_c >= WIN_LEVEL) begin
            state_d  = S_OVER;
            winner_d = firstPlayerFlag;
          end else begin
            state_d = S_SHOW;
          end
        end

        S_SHOW: begin
          if (timer_q == HOLD_LAST) begin
            state_d = S_RELEASE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end

        S_RELEASE: begin
          if (!playerInputFlag) begin
            state_d = S_ARMED;
            timer_d = '0;
          end
        end

        S_OVER: begin
          if (timer_q == HOLD_LAST) begin
            timer_d = '0;
            led_d   = ~led_q;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end

    // Outside OVER the LED simply marks an open round
    if (state_d != S_OVER) led_d = (state_d == S_ARMED);
  end

  assign scores       = score_q;
  assign state        = state_q;
  assign last_player  = last_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign winner       = winner_q;
  assign led          = led_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with short TIMEOUT/HOLD and a low win score.
module tb_quiz_round_ctrl;

  localparam int unsigned TIMEOUT   = 50;
  localparam int unsigned HOLD      = 10;
  localparam int unsigned SCORE_W   = 4;
  localparam int unsigned WIN_SCORE = 3;

  logic                 clk;
  logic                 rst;
  logic                 gameHasStarted;
  logic                 playerInputFlag;
  logic                 allButtons;
  logic [1:0]           firstPlayerFlag;
  logic [7:0]           switchInput;
  logic [7:0]           answer_key;
  logic [4*SCORE_W-1:0] scores;
  logic [2:0]           state;
  logic [1:0]           last_player;
  logic [1:0]           result;
  logic                 result_valid;
  logic [1:0]           winner;
  logic                 led;

  int checks   = 0;
  int failures = 0;

  quiz_round_ctrl #(
    .TIMEOUT  (TIMEOUT),
    .HOLD     (HOLD),
    .SCORE_W  (SCORE_W),
    .WIN_SCORE(WIN_SCORE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gameHasStarted (gameHasStarted),
    .playerInputFlag(playerInputFlag),
    .allButtons     (allButtons),
    .firstPlayerFlag(firstPlayerFlag),
    .switchInput    (switchInput),
    .answer_key     (answer_key),
    .scores         (scores),
    .state          (state),
    .last_player    (last_player),
    .result         (result),
    .result_valid   (result_valid),
    .winner         (winner),
    .led            (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n active edges; outputs are then sampled 1 time unit after the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(2);
    checks++;
    if (state !== 3'd0) begin
      $display("FAIL reset_state got=%0d exp=0", state); failures++;
    end
    checks++;
    if (scores !== 16'h0000) begin
      $display("FAIL reset_scores got=%h exp=0000", scores); failures++;
    end
    checks++;
    if ({led, result_valid, result, last_player, winner} !== 8'h00) begin
      $display("FAIL reset_outputs got=%b exp=00000000",
               {led, result_valid, result, last_player, winner}); failures++;
    end
    rst = 1'b1;
    gameHasStarted = 1'b1;
    tick(1);
    gameHasStarted = 1'b0;
    checks++;
    if (state !== 3'd1 || led !== 1'b1) begin
      $display("FAIL start_armed got state=%0d led=%b exp state=1 led=1", state, led); failures++;
    end
  endtask

  task automatic test_correct;
    playerInputFlag = 1'b1;
    firstPlayerFlag = 2'd2;
    switchInput     = 8'h5A;
    tick(1);
    checks++;
    if (state !== 3'd2 || result_valid !== 1'b0) begin
      $display("FAIL correct_capture got state=%0d rv=%b exp state=2 rv=0", state, result_valid); failures++;
    end
    tick(1);
    checks++;
    if (state !== 3'd3 || result !== 2'b01 || result_valid !== 1'b1) begin
      $display("FAIL correct_judge got state=%0d res=%b rv=%b exp 3/01/1", state, result, result_valid); failures++;
    end
    checks++;
    if (scores !== 16'h0100 || last_player !== 2'd2) begin
      $display("FAIL correct_score got scores=%h lp=%0d exp 0100/2", scores, last_player); failures++;
    end
    tick(1);
    checks++;
    if (result_valid !== 1'b0 || led !== 1'b0) begin
      $display("FAIL correct_pulse got rv=%b led=%b exp 0/0", result_valid, led); failures++;
    end
    tick(8);
    checks++;
    if (state !== 3'd3) begin
      $display("FAIL show_hold got=%0d exp=3", state); failures++;
    end
    tick(1);
    checks++;
    if (state !== 3'd4) begin
      $display("FAIL show_release got=%0d exp=4", state); failures++;
    end
    tick(2);
    checks++;
    if (state !== 3'd4) begin
      $display("FAIL release_held got=%0d exp=4", state); failures++;
    end
    playerInputFlag = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd1 || led !== 1'b1) begin
      $display("FAIL release_rearm got state=%0d led=%b exp 1/1", state, led); failures++;
    end
  endtask

  task automatic test_wrong_floor;
    playerInputFlag = 1'b1;
    firstPlayerFlag = 2'd0;
    switchInput     = 8'h00;
    tick(2);
    playerInputFlag = 1'b0;
    checks++;
    if (result !== 2'b10 || result_valid !== 1'b1 || last_player !== 2'd0) begin
      $display("FAIL wrong_judge got res=%b rv=%b lp=%0d exp 10/1/0", result, result_valid, last_player); failures++;
    end
    checks++;
    if (scores !== 16'h0100) begin
      $display("FAIL wrong_floor got=%h exp=0100", scores); failures++;
    end
    tick(11);
    checks++;
    if (state !== 3'd1) begin
      $display("FAIL wrong_rearm got=%0d exp=1", state); failures++;
    end
  endtask

  task automatic test_timeout;
    tick(49);
    checks++;
    if (state !== 3'd1) begin
      $display("FAIL timeout_early got=%0d exp=1", state); failures++;
    end
    tick(1);
    checks++;
    if (state !== 3'd3 || result !== 2'b11 || result_valid !== 1'b1) begin
      $display("FAIL timeout_show got state=%0d res=%b rv=%b exp 3/11/1", state, result, result_valid); failures++;
    end
    checks++;
    if (scores !== 16'h0100 || last_player !== 2'd0) begin
      $display("FAIL timeout_scores got scores=%h lp=%0d exp 0100/0", scores, last_player); failures++;
    end
    tick(11);
    checks++;
    if (state !== 3'd1) begin
      $display("FAIL timeout_rearm got=%0d exp=1", state); failures++;
    end
    // Buzz lands on the terminal timer cycle
    tick(49);
    playerInputFlag = 1'b1;
    firstPlayerFlag = 2'd1;
    switchInput     = 8'h5A;
    tick(1);
    checks++;
    if (state !== 3'd2) begin
      $display("FAIL buzz_wins got=%0d exp=2", state); failures++;
    end
    tick(1);
    playerInputFlag = 1'b0;
    checks++;
    if (result !== 2'b01 || scores !== 16'h0110) begin
      $display("FAIL buzz_wins_judge got res=%b scores=%h exp 01/0110", result, scores); failures++;
    end
    tick(11);
  endtask

  task automatic test_win;
    for (int r = 0; r < 2; r++) begin
      playerInputFlag = 1'b1;
      firstPlayerFlag = 2'd3;
      switchInput     = 8'h5A;
      tick(2);
      playerInputFlag = 1'b0;
      tick(11);
    end
    checks++;
    if (scores !== 16'h2110 || state !== 3'd1) begin
      $display("FAIL win_progress got scores=%h state=%0d exp 2110/1", scores, state); failures++;
    end
    playerInputFlag = 1'b1;
    tick(2);
    playerInputFlag = 1'b0;
    checks++;
    if (state !== 3'd5 || winner !== 2'd3) begin
      $display("FAIL win_over got state=%0d winner=%0d exp 5/3", state, winner); failures++;
    end
    checks++;
    if (scores !== 16'h3110 || result !== 2'b01 || led !== 1'b0) begin
      $display("FAIL win_outputs got scores=%h res=%b led=%b exp 3110/01/0", scores, result, led); failures++;
    end
    tick(9);
    checks++;
    if (led !== 1'b0) begin
      $display("FAIL over_led_early got=%b exp=0", led); failures++;
    end
    tick(1);
    checks++;
    if (led !== 1'b1) begin
      $display("FAIL over_led_toggle got=%b exp=1", led); failures++;
    end
    playerInputFlag = 1'b1;
    firstPlayerFlag = 2'd0;
    tick(10);
    playerInputFlag = 1'b0;
    checks++;
    if (state !== 3'd5 || scores !== 16'h3110 || led !== 1'b0) begin
      $display("FAIL over_ignore got state=%0d scores=%h led=%b exp 5/3110/0", state, scores, led); failures++;
    end
  endtask

  task automatic test_abort;
    allButtons = 1'b1;
    tick(1);
    allButtons = 1'b0;
    checks++;
    if (state !== 3'd0 || scores !== 16'h0000) begin
      $display("FAIL abort_over got state=%0d scores=%h exp 0/0000", state, scores); failures++;
    end
    gameHasStarted = 1'b1;
    tick(1);
    gameHasStarted  = 1'b0;
    playerInputFlag = 1'b1;
    firstPlayerFlag = 2'd0;
    switchInput     = 8'h5A;
    tick(2);
    playerInputFlag = 1'b0;
    checks++;
    if (state !== 3'd3 || scores !== 16'h0001) begin
      $display("FAIL abort_setup got state=%0d scores=%h exp 3/0001", state, scores); failures++;
    end
    tick(3);
    allButtons = 1'b1;
    tick(1);
    allButtons = 1'b0;
    checks++;
    if (state !== 3'd0 || scores !== 16'h0000 || result !== 2'b00) begin
      $display("FAIL abort_show got state=%0d scores=%h res=%b exp 0/0000/00", state, scores, result); failures++;
    end
    checks++;
    if (led !== 1'b0 || result_valid !== 1'b0) begin
      $display("FAIL abort_flags got led=%b rv=%b exp 0/0", led, result_valid); failures++;
    end
  endtask

  task automatic test_reset_capture;
    gameHasStarted  = 1'b1;
    playerInputFlag = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd0) begin
      $display("FAIL idle_held_buzz got=%0d exp=0", state); failures++;
    end
    playerInputFlag = 1'b0;
    tick(1);
    gameHasStarted = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      $display("FAIL idle_release_start got=%0d exp=1", state); failures++;
    end
    playerInputFlag = 1'b1;
    firstPlayerFlag = 2'd0;
    switchInput     = 8'h5A;
    tick(1);
    checks++;
    if (state !== 3'd2) begin
      $display("FAIL rst_setup got=%0d exp=2", state); failures++;
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (state !== 3'd0 || scores !== 16'h0000 || result !== 2'b00 || result_valid !== 1'b0) begin
      $display("FAIL rst_capture got state=%0d scores=%h res=%b rv=%b exp 0/0000/00/0",
               state, scores, result, result_valid); failures++;
    end
    rst = 1'b1;
    playerInputFlag = 1'b0;
    tick(1);
  endtask

  initial begin
    rst             = 1'b0;
    gameHasStarted  = 1'b0;
    playerInputFlag = 1'b0;
    allButtons      = 1'b0;
    firstPlayerFlag = 2'd0;
    switchInput     = 8'h00;
    answer_key      = 8'h5A;
    test_reset();
    test_correct();
    test_wrong_floor();
    test_timeout();
    test_win();
    test_abort();
    test_reset_capture();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Game-round controller directly downstream of the four-player controller front end.
- Consumes that front end's buzz flag, registered first-player index and registered 8-bit switch answer, plus the start and all-buttons signals.
- Runs timed rounds, judges each captured answer against a host-supplied key, and keeps a saturating score per player.
- Declares a winner and drives status outputs for the display/LED logic.

Parameters:
TIMEOUT, 500000000, cycles ARMED waits for a buzz before the round expires (10 s at 50 MHz)
HOLD, 100000000, cycles a round result is held in SHOW (2 s)
SCORE_W, 4, bits per player score
WIN_SCORE, 5, score value that ends the game

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous active-low reset
gameHasStarted  in  1  level; start request (any button held 5 s)
playerInputFlag  in  1  level; some single player is buzzing
allButtons  in  1  level; all four buttons held (abort/new game)
firstPlayerFlag  in  2  registered buzzing player index, valid 1 cycle after playerInputFlag rises
switchInput  in  8  registered player answer, valid 1 cycle after playerInputFlag rises
answer_key  in  8  correct answer for current round, static while ARMED
scores  out  4*SCORE_W  {p4,p3,p2,p1} scores, p1 in LSBs
state  out  3  IDLE=0, ARMED=1, CAPTURE=2, SHOW=3, RELEASE=4, OVER=5
last_player  out  2  player captured in last judged round
result  out  2  00 none, 01 correct, 10 wrong, 11 timeout
result_valid  out  1  one-cycle pulse when result is updated
winner  out  2  winning player, valid in OVER
led  out  1  1 while ARMED (round open)

Behaviour:
- Clock: all state changes on posedge clk.
- Reset (rst=0 at posedge):
  - state=IDLE; scores=0; last_player=0; result=00; result_valid=0; winner=0; led=0; timer=0.
  - Reset wins over every other input.
- Abort: allButtons=1 in any state other than IDLE → next state IDLE, scores=0, result=00, timer=0. Abort has priority over all transitions below.
- IDLE:
  - gameHasStarted=1 and playerInputFlag=0 → ARMED, timer=0.
  - gameHasStarted=1 with playerInputFlag=1 → remain IDLE until release.
- ARMED (led=1):
  - Each cycle, timer increments.
  - playerInputFlag=1 → CAPTURE.
  - Otherwise, timer==TIMEOUT-1 → SHOW with result=11, result_valid pulse, scores unchanged.
  - If a buzz and the timeout occur in the same cycle, the buzz wins.
- CAPTURE (exactly 1 cycle, absorbs the upstream register latency):
  - Sample firstPlayerFlag → last_player; compare switchInput with answer_key.
  - Equal: result=01, score[p] += 1, saturating at 2^SCORE_W-1.
  - Not equal: result=10, score[p] -= 1, saturating at 0.
  - result_valid=1 for this one cycle.
  - If the post-update score[p] >= WIN_SCORE → OVER, winner=p. Else → SHOW.
  - Timer cleared.
- SHOW:
  - Timer counts.
  - timer==HOLD-1 → RELEASE, timer=0.
- RELEASE: playerInputFlag=0 → ARMED, timer=0. Prevents a held button from re-buzzing.
- OVER:
  - Hold scores and winner.
  - led toggles every HOLD cycles: timer counts, wraps at HOLD-1.
  - Exit only via abort or reset.
- Score arithmetic:
  - Performed at SCORE_W bits with saturation; no wrap in either direction.
  - Scores of non-captured players never change.
- result / last_player hold their values until the next judged or timed-out round, or until abort/reset.
- Timer: 32-bit counter; it never exceeds its terminal value.

Test Plan:
- Reset and start: rst=0 for 2 cycles → state=0, scores=0. Then rst=1, gameHasStarted=1 → state=1 and led=1 on the next cycle.
- Correct answer: TIMEOUT=50, HOLD=10, answer_key=8'h5A. Buzz with firstPlayerFlag=2, switchInput=8'h5A → CAPTURE 1 cycle after the buzz, result=01, result_valid pulse, scores=16'h0100. SHOW for 10 cycles, then RELEASE; ARMED resumes after playerInputFlag drops.
- Wrong answer at zero: player 1 answers 8'h00 with key 8'h5A → result=10, p1 score stays 0 (floor saturation).
- Timeout: no buzz for 50 cycles → SHOW with result=11 and scores unchanged. A buzz exactly on cycle 49 instead → CAPTURE (buzz wins).
- Win: WIN_SCORE=3; player 4 answers correctly 3 times → OVER, winner=3, scores[15:12]=3, led toggles every 10 cycles. Further buzzes are ignored.
- Abort and reset: allButtons=1 during SHOW with nonzero scores → IDLE, scores=0, result=00. Separately, rst=0 during CAPTURE → IDLE with no score update.
